// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM/owner encodings and the round-robin pick for the
// instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int W_OPR = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Lone requester wins; on contention the side that did not go last wins.
  function automatic owner_e pick_owner(input logic if_req, input logic ls_req,
                                        input owner_e last);
    return (ls_req && (!if_req || last == OWN_IF)) ? OWN_LS : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle counter for one memory access; expired_o flags the last
// permitted cycle of mem_req_o before the access is aborted.
module mem_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int W_TO    = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W_TO-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == W_TO'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin IF / LD-ST arbiter and sequencer for the single-ported memory.
// Every output comes straight from a flop.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int W_OPR   = mem_arbiter_pkg::W_OPR,
  parameter int TIMEOUT = 255,
  parameter int W_TO    = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             if_req_i,
  input  logic [W_OPR-1:0] if_addr_i,
  output logic             if_ack_o,
  output logic [W_OPR-1:0] if_rdata_o,
  input  logic             ls_req_i,
  input  logic [W_OPR-1:0] ls_addr_i,
  input  logic             ls_write_i,
  input  logic [W_OPR-1:0] ls_wdata_i,
  output logic             ls_ack_o,
  output logic [W_OPR-1:0] ls_rdata_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             mem_req_o,
  output logic [W_OPR-1:0] mem_addr_o,
  output logic             mem_we_o,
  output logic [W_OPR-1:0] mem_wdata_o,
  input  logic             mem_ready_i,
  input  logic [W_OPR-1:0] mem_rdata_i
);

  state_e           state_q, state_d;
  owner_e           own_q, own_d, last_q, last_d, grant;
  logic [W_OPR-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [W_OPR-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d, rd;
  logic             we_q, we_d, req_q, req_d, busy_q, busy_d;
  logic             if_ack_q, if_ack_d, ls_ack_q, ls_ack_d, err_q, err_d;
  logic             wd_clr, wd_en, wd_expired;

  mem_watchdog #(.TIMEOUT(TIMEOUT), .W_TO(W_TO)) u_wd (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  assign grant = pick_owner(if_req_i, ls_req_i, last_q);

  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    last_d     = last_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    req_d      = req_q;
    busy_d     = busy_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_ack_d   = 1'b0;
    ls_ack_d   = 1'b0;
    err_d      = 1'b0;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    rd         = '0;
    case (state_q)
      ST_IDLE: begin
        if (if_req_i || ls_req_i) begin
          own_d   = grant;
          last_d  = grant;
          addr_d  = (grant == OWN_LS) ? ls_addr_i : if_addr_i;
          we_d    = (grant == OWN_LS) && ls_write_i;
          wdata_d = (grant == OWN_LS) ? ls_wdata_i : '0;
          wd_clr  = 1'b1;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Ready in the final permitted cycle still completes normally.
        if (mem_ready_i || wd_expired) begin
          rd = (mem_ready_i && !we_q) ? mem_rdata_i : '0;
          if (own_q == OWN_LS) begin
            ls_rdata_d = rd;
            ls_ack_d   = 1'b1;
          end else begin
            if_rdata_d = rd;
            if_ack_d   = 1'b1;
          end
          err_d   = !mem_ready_i;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          wd_en = 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      own_q      <= OWN_IF;
      last_q     <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_ack_q   <= if_ack_d;
      ls_ack_q   <= ls_ack_d;
      err_q      <= err_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_ack_o    = ls_ack_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and two-way arbiter for the single-ported data/instruction memory. Accepts fetch requests from the IF stage and load/store requests from the LD/ST execute path (address, write flag and store data already resolved), grants one at a time round-robin, drives the memory handshake, returns read data with a one-cycle acknowledge, and aborts any access the memory fails to complete within a bounded number of cycles.

## Interface
- W_OPR, 32: address and data width (from shared params).
- TIMEOUT, 255: maximum cycles `mem_req_o` stays high without `mem_ready_i` before abort; legal range 1..2^W_TO-1.
- W_TO, 8: timeout counter width.
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held high until `if_ack_o`.
- if_addr_i  in  W_OPR  fetch address; stable while `if_req_i` high.
- if_ack_o  out  1  one-cycle completion pulse for fetch.
- if_rdata_o  out  W_OPR  fetched word, valid when `if_ack_o`.
- ls_req_i  in  1  load/store request; held high until `ls_ack_o`.
- ls_addr_i  in  W_OPR  effective address.
- ls_write_i  in  1  1 = store, 0 = load.
- ls_wdata_i  in  W_OPR  store data.
- ls_ack_o  out  1  one-cycle completion pulse for load/store.
- ls_rdata_o  out  W_OPR  load data, valid when `ls_ack_o`.
- err_o  out  1  pulses with the ack of an aborted (timed-out) access.
- busy_o  out  1  high whenever state ≠ IDLE.
- mem_req_o  out  1  memory request, registered.
- mem_addr_o  out  W_OPR  latched address.
- mem_we_o  out  1  latched write enable.
- mem_wdata_o  out  W_OPR  latched store data.
- mem_ready_i  in  1  memory completes current access this cycle.
- mem_rdata_i  in  W_OPR  read data, valid with `mem_ready_i`.

## Operation
- States: IDLE, BUSY, DONE. Owner register `own` (0 = IF, 1 = LS); round-robin pointer `last` (granted owner of the previous access).
- IDLE: no request → stay. One request → grant it. Both → grant the one ≠ `last`. On grant: latch addr/we/wdata (IF: we=0, wdata=0), set `own`, `last`, clear counter, → BUSY.
- BUSY: `mem_req_o`=1. `mem_ready_i`=1 → capture `mem_rdata_i` (load/fetch) or 0 (store) into owner's rdata register, → DONE. Else counter+1; counter reaching TIMEOUT−1 without ready → rdata=0, set error flag, → DONE.
- DONE: owner's ack=1, err_o=error flag, `mem_req_o`=0; no grant evaluated; → IDLE, clear error flag.
- Non-owner rdata register holds its last value; acks/err_o are 0 outside DONE.
- Request dropped while BUSY is a protocol violation; access still completes and acks.
- `mem_addr_o`/`mem_we_o`/`mem_wdata_o` hold latched values after completion until next grant.
- Reset (any time, including mid-access): state IDLE, `last`=IF (LS wins first contention), counter 0, all outputs 0, rdata registers 0. In-flight access is dropped without ack.

## Timing
- All outputs registered; no combinational path input→output.
- Minimum access: request sampled in IDLE at edge of cycle 0; `mem_req_o` high cycle 1; ready in cycle 1 → ack cycle 2; IDLE cycle 3 (new grant sampled). Throughput one access per 3 cycles, plus memory wait cycles.
- Timeout: `mem_req_o` high exactly TIMEOUT cycles, ack+err_o in the following cycle.
- `mem_ready_i` outside BUSY ignored.
- Request rising during DONE is not granted until the next IDLE cycle.

## Structure
- Shared params include: W_OPR, state encodings (IDLE/BUSY/DONE), owner encodings (OWN_IF/OWN_LS).
- One sub-module: `mem_watchdog` (clear, enable, TIMEOUT compare, `expired` output); rest is a single FSM in `mem_arbiter`.

## Test plan
- Single fetch, addr 0x100, memory ready in first BUSY cycle returning 0xDEADBEEF -> `mem_req_o` high cycle 1 only, `if_ack_o` and `if_rdata_o`=0xDEADBEEF cycle 2, `busy_o` low cycle 3.
- Store addr 0x40 data 0x1234 with 3 wait cycles -> `mem_we_o`=1, `mem_wdata_o`=0x1234 held 4 cycles, `ls_ack_o` pulse, `ls_rdata_o`=0, `err_o`=0.
- Both requesters high continuously from reset -> grant order LS, IF, LS, IF; each ack exactly once per access, no back-to-back grant in DONE.
- Memory never ready, TIMEOUT=4 -> `mem_req_o` high 4 cycles, then `ls_ack_o`=1, `err_o`=1, `ls_rdata_o`=0; next access proceeds normally with `err_o`=0.
- `rst_n_i` asserted during BUSY -> all outputs 0 asynchronously, no ack; after release, pending IF and LS both high -> LS granted first.
- `mem_ready_i` pulsed while IDLE and in DONE -> no state change, no spurious ack.
